conv2d_stream: RTL and testbench

Parametrised streaming 2-D convolution engine, successor to the fixed 32x32 `cnn_top` array core. Pixels arrive one per handshake in raster order and pass through K-1 line buffers into a KxK window. A signed MAC, shift, saturate and optional-ReLU stage produces one valid-mode output per complete window, with full backpressure. Coefficients are loaded through a write port while idle; a frame is launched by `start` and ends with a `done` pulse.

---
 rtl/conv2d_stream_if.sv | 8 +
 rtl/conv2d_stream.sv | 121 ++++++++++++
 tb/tb_conv2d_stream.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if: pixel-in / result-out handshake bundle for the convolution engine
interface conv2d_stream_if #(parameter int DATA_W = 16, parameter int OUT_W = 16);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [DATA_W-1:0] in_data;
  logic signed [OUT_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK valid-mode convolution with shift, saturation, optional ReLU and backpressure
module conv2d_stream #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K = 3,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W = 16,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(K * K),
  localparam int CA_W = (K * K > 1) ? $clog2(K * K) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     relu_en_i,
  input  logic [5:0]               shift_i,
  input  logic                     coef_we_i,
  input  logic [CA_W-1:0]          coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_data_i,
  conv2d_stream_if.slave           s,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int L = (K - 1) * IMG_W + K;
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic signed [COEF_W-1:0] coef_q [K*K];
  logic signed [DATA_W-1:0] sr_q [L];
  logic relu_q, done_q, v0_q, l0_q, v1_q, l1_q, out_valid_q, out_last_q;
  logic [5:0] shift_q;
  logic signed [ACC_W-1:0] sum_q, sum_d, shr;
  logic signed [OUT_W-1:0] out_data_q, sat, res;
  logic en, acc, col_end, row_end, win_ok, hs_last;
  assign en = !(out_valid_q && !s.out_ready);
  assign s.in_ready = en && state_q == RUN;
  assign acc = s.in_valid && s.in_ready;
  assign col_end = col_q == CW'(IMG_W - 1);
  assign row_end = row_q == RW'(IMG_H - 1);
  assign win_ok = row_q >= RW'(K - 1) && col_q >= CW'(K - 1);
  assign hs_last = out_valid_q && s.out_ready && out_last_q;
  assign s.out_valid = out_valid_q;
  assign s.out_data = out_data_q;
  assign s.out_last = out_last_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  // frame control: launch, raster position of the next pixel, drain until the last result leaves
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      relu_q <= 1'b0;
      shift_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state_q == DRAIN && hs_last;
      case (state_q)
        IDLE: if (start_i && !done_q) begin
          state_q <= RUN;
          col_q <= '0;
          row_q <= '0;
          relu_q <= relu_en_i;
          shift_q <= shift_i;
        end
        RUN: if (acc) begin
          col_q <= col_end ? '0 : col_q + 1'b1;
          row_q <= col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
          if (col_end && row_end) state_q <= DRAIN;
        end
        DRAIN: if (hs_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  // coefficient store, writable only between frames; out-of-range addresses dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < K * K; i++) coef_q[i] <= '0;
    else if (coef_we_i && state_q == IDLE && 32'(coef_addr_i) < K * K) coef_q[coef_addr_i] <= coef_data_i;
  // line buffers and window as one pixel delay chain; index 0 is the newest pixel
  always_ff @(posedge clk)
    if (acc) begin
      sr_q[0] <= s.in_data;
      for (int i = 1; i < L; i++) sr_q[i] <= sr_q[i-1];
    end
  // window MAC: coef[0][0] meets the oldest (top-left) pixel
  always_comb begin
    sum_d = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        sum_d = sum_d + ACC_W'(sr_q[(K-1-r)*IMG_W + K-1-c]) * ACC_W'(coef_q[r*K+c]);
  end
  assign shr = sum_q >>> shift_q;
  assign sat = shr > SMAX ? OUT_W'(SMAX) : shr < SMIN ? OUT_W'(SMIN) : OUT_W'(shr);
  assign res = relu_q && sat[OUT_W-1] ? '0 : sat;
  // MAC and output stages, all frozen while a result waits for out_ready
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0_q <= 1'b0;
      l0_q <= 1'b0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      sum_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else if (en) begin
      v0_q <= acc && win_ok;
      l0_q <= acc && col_end && row_end;
      v1_q <= v0_q;
      l1_q <= l0_q;
      if (v0_q) sum_q <= sum_d;
      out_valid_q <= v1_q;
      out_last_q <= l1_q;
      if (v1_q) out_data_q <= res;
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: table, hand-written and random frames checked against a loop-based convolution model
module tb_conv2d_stream;
  localparam int W = 5, H = 5, K = 3, N = W * H, NO = (W - K + 1) * (H - K + 1);
  typedef struct {string name; int pmode; int cmode; bit relu; int sh; int first; int last;} vec_t;
  logic clk = 0, rst_n = 0, start = 0, relu_en = 0, coef_we = 0, busy, done;
  logic [5:0] shift = 0;
  logic [3:0] coef_addr = 0;
  logic signed [15:0] coef_data = 0;
  int pix [N];
  int coef [K*K];
  int got_q [$], exp_q [$], prev_q [$];
  bit last_q [$];
  int checks = 0, errors = 0, stall_cycles = 0;
  bit stall_bad = 0;
  vec_t vecs [8];
  always #5 clk = ~clk;
  conv2d_stream_if #(.DATA_W(16), .OUT_W(16)) sif ();
  conv2d_stream #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(16), .COEF_W(16), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .relu_en_i(relu_en), .shift_i(shift),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .s(sif), .busy_o(busy), .done_o(done));

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void model(input bit relu, input int sh);
    longint acc;
    exp_q.delete();
    for (int orow = 0; orow <= H - K; orow++)
      for (int ocol = 0; ocol <= W - K; ocol++) begin
        acc = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) acc += longint'(pix[(orow + r) * W + ocol + c]) * coef[r * K + c];
        acc = acc >>> sh;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        exp_q.push_back(int'(acc));
      end
  endfunction

  task automatic load_coefs();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      coef_we = 1;
      coef_addr = 4'(i);
      coef_data = i < K * K ? 16'(coef[i]) : 16'sh7fff;
    end
    @(posedge clk); #1;
    coef_we = 0;
  endtask

  task automatic run_frame(input string tag, input bit relu, input int sh, input int rmode, input bit inject, input int abort_at);
    int pi = 0, cyc = 0, stall_left = 0;
    bit exp_done = 0, fin = 0, stalled = 0, prev_stall = 0;
    int prev_data = 0;
    got_q.delete();
    last_q.delete();
    @(posedge clk); #1;
    start = 1; relu_en = relu; shift = 6'(sh);
    @(posedge clk); #1;
    start = 0; relu_en = !relu; shift = 6'($urandom);
    while (!fin && cyc < 3000) begin
      sif.in_valid = pi < N && (rmode != 1 || $urandom_range(3) != 0);
      sif.in_data = 16'(pix[pi < N ? pi : 0]);
      if (rmode == 2) begin
        if (!stalled && got_q.size() == 4) begin stalled = 1; stall_left = 10; end
        sif.out_ready = stall_left == 0;
        if (stall_left > 0) stall_left--;
      end else sif.out_ready = rmode == 1 ? 1'($urandom_range(1)) : 1'b1;
      coef_we = inject && cyc == 6;
      start = coef_we;
      coef_addr = 4'd4;
      coef_data = 16'sd100;
      @(negedge clk);
      if (exp_done) begin
        check({tag, " done_pulse"}, int'(done), 1);
        check({tag, " busy_with_done"}, int'(busy), 0);
        fin = 1;
      end else if (done) begin
        checks++; errors++;
        $display("FAIL %s early_done: done=1 before out_last handshake", tag);
        fin = 1;
      end
      if (rmode == 2 && sif.out_valid && !sif.out_ready) begin
        stall_cycles++;
        if (sif.in_ready) stall_bad = 1;
        if (prev_stall && int'(sif.out_data) != prev_data) stall_bad = 1;
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data = int'(sif.out_data);
      if (sif.in_valid && sif.in_ready) pi++;
      if (sif.out_valid && sif.out_ready) begin
        got_q.push_back(int'(sif.out_data));
        last_q.push_back(sif.out_last);
        if (sif.out_last) exp_done = 1;
      end
      if (abort_at > 0 && pi == abort_at) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin && abort_at == 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done after %0d cycles, got %0d outputs", tag, cyc, got_q.size());
    end
    coef_we = 0; start = 0;
    if (abort_at == 0) sif.in_valid = 0;
    sif.out_ready = 1;
  endtask

  task automatic compare(input string tag);
    int nlast = 0, lidx = -1;
    check({tag, " count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) check($sformatf("%s out[%0d]", tag, i), i < got_q.size() ? got_q[i] : -99999, exp_q[i]);
    foreach (last_q[i]) if (last_q[i]) begin nlast++; lidx = i; end
    check({tag, " last_index"}, nlast == 1 ? lidx : -nlast - 100, NO - 1);
  endtask

  task automatic set_frame(input int pmode, input int cmode);
    for (int i = 0; i < N; i++) pix[i] = pmode == 0 ? i : pmode == 1 ? 32767 : -32768;
    for (int i = 0; i < K * K; i++) coef[i] = cmode == 1 ? 1 : (i == 4 ? (cmode == 2 ? -1 : 1) : 0);
  endtask

  initial begin
    vecs[0] = '{"identity", 0, 0, 0, 0, 6, 18};
    vecs[1] = '{"ones", 0, 1, 0, 0, 54, 162};
    vecs[2] = '{"ones_sh2", 0, 1, 0, 2, 13, 40};
    vecs[3] = '{"sat_max", 1, 1, 0, 0, 32767, 32767};
    vecs[4] = '{"sat_min", 2, 1, 0, 0, -32768, -32768};
    vecs[5] = '{"relu_min", 2, 1, 1, 0, 0, 0};
    vecs[6] = '{"neg_id", 0, 2, 0, 0, -6, -18};
    vecs[7] = '{"neg_id_relu", 0, 2, 1, 0, 0, 0};
    sif.in_valid = 0; sif.in_data = 0; sif.out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    check("rst in_ready", int'(sif.in_ready), 0);
    check("rst out_valid", int'(sif.out_valid), 0);
    check("rst out_last", int'(sif.out_last), 0);
    check("rst out_data", int'(sif.out_data), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    @(negedge clk);
    rst_n = 1;
    foreach (vecs[v]) begin
      set_frame(vecs[v].pmode, vecs[v].cmode);
      load_coefs();
      model(vecs[v].relu, vecs[v].sh);
      run_frame(vecs[v].name, vecs[v].relu, vecs[v].sh, 0, 0, 0);
      check({vecs[v].name, " first"}, got_q.size() > 0 ? got_q[0] : -99999, vecs[v].first);
      check({vecs[v].name, " last"}, got_q.size() > 0 ? got_q[got_q.size() - 1] : -99999, vecs[v].last);
      compare(vecs[v].name);
    end
    set_frame(0, 1);
    load_coefs();
    model(0, 0);
    run_frame("backpressure", 0, 0, 2, 0, 0);
    compare("backpressure");
    check("stall observed", int'(stall_cycles >= 5), 1);
    check("stall hold rules", int'(stall_bad), 0);
    run_frame("gating", 0, 0, 0, 1, 0);
    compare("gating");
    prev_q = got_q;
    run_frame("back_to_back", 0, 0, 0, 0, 0);
    compare("back_to_back");
    foreach (prev_q[i]) check($sformatf("b2b same[%0d]", i), i < got_q.size() ? got_q[i] : -99999, prev_q[i]);
    run_frame("abort", 0, 0, 0, 0, 12);
    check("abort busy before reset", int'(busy), 1);
    #2;
    rst_n = 0;
    #1;
    check("midrst in_ready", int'(sif.in_ready), 0);
    check("midrst out_valid", int'(sif.out_valid), 0);
    check("midrst out_data", int'(sif.out_data), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    sif.in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    set_frame(0, 0);
    for (int i = 0; i < K * K; i++) coef[i] = 0;
    model(0, 0);
    run_frame("cleared_coefs", 0, 0, 0, 0, 0);
    compare("cleared_coefs");
    set_frame(0, 0);
    load_coefs();
    model(0, 0);
    run_frame("after_reset", 0, 0, 0, 0, 0);
    compare("after_reset");
    for (int f = 0; f < 6; f++) begin
      bit relu = 1'($urandom_range(1));
      int sh = $urandom_range(20);
      for (int i = 0; i < N; i++) pix[i] = f < 3 ? $urandom_range(511) - 256 : int'(16'($urandom)) - 32768;
      for (int i = 0; i < K * K; i++) coef[i] = f[0] ? int'($urandom_range(65535)) - 32768 : $urandom_range(63) - 32;
      load_coefs();
      model(relu, sh);
      run_frame($sformatf("rand%0d", f), relu, sh, 1, 0, 0);
      compare($sformatf("rand%0d", f));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
